// File: rtl/hough_uart_pkg.sv
// Shared definitions for the UART Hough/Sobel ingest path.
package hough_uart_pkg;

    localparam logic [7:0]  SYNC_BYTE0 = 8'hAA;
    localparam logic [7:0]  SYNC_BYTE1 = 8'h55;
    localparam int unsigned PIXEL_BITS = 24;

    typedef enum logic [2:0] {
        SYNC0,
        SYNC1,
        PIXEL,
        CHECK,
        DONE
    } frame_rx_state_t;

endpackage

// File: rtl/rx_idle_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last received byte
// and flags (combinationally) the cycle in which the limit is reached.
module rx_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Idle count: restarts on every byte and whenever the receiver is idle.
    always_ff @(posedge clk) begin
        if (reset || clear || !enable) begin
            count <= '0;
        end else if (count != TERMINAL) begin
            count <= count + CNT_W'(1);
        end
    end

    // A byte arriving in the terminal cycle takes priority over the timeout.
    assign expired_c = enable && !clear && (count == TERMINAL);

endmodule

// File: rtl/uart_frame_rx.sv
// UART frame ingest: hunts for the AA 55 header, packs B,G,R bytes into
// 24-bit pixels and writes them sequentially into the frame buffer.
// Optional trailing XOR checksum enabled by defining FRAME_RX_CHECKSUM_EN.
module uart_frame_rx
    import hough_uart_pkg::*;
#(
    parameter int unsigned IMG_WIDTH      = 1280,
    parameter int unsigned IMG_HEIGHT     = 720,
    parameter int unsigned ADDR_WIDTH     = $clog2(IMG_WIDTH * IMG_HEIGHT),
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_enable,
    output logic                  fb_wr_en,
    output logic [ADDR_WIDTH-1:0] fb_wr_addr,
    output logic [PIXEL_BITS-1:0] fb_wr_data,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int unsigned        CNT_W      = ADDR_WIDTH + 1;
    localparam int unsigned        FRAME_PIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [CNT_W-1:0]   LAST_PIXEL = CNT_W'(FRAME_PIX - 1);

    frame_rx_state_t       state, state_d;
    logic [1:0]            phase, phase_d;
    logic [CNT_W-1:0]      pix_cnt, pix_cnt_d;
    logic [7:0]            b_q, b_d;
    logic [7:0]            g_q, g_d;
    logic                  wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic [PIXEL_BITS-1:0] wr_data_d;
    logic                  done_d;
    logic                  error_d;
    logic                  busy_d;
    logic                  expired_c;
`ifdef FRAME_RX_CHECKSUM_EN
    logic [7:0]            xor_q, xor_d;
`endif

    rx_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (rx_valid),
        .enable   (busy),
        .expired_c(expired_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SYNC0;
            phase       <= 2'd0;
            pix_cnt     <= '0;
            b_q         <= 8'd0;
            g_q         <= 8'd0;
            fb_wr_en    <= 1'b0;
            fb_wr_addr  <= '0;
            fb_wr_data  <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
`ifdef FRAME_RX_CHECKSUM_EN
            xor_q       <= 8'd0;
`endif
        end else begin
            state       <= state_d;
            phase       <= phase_d;
            pix_cnt     <= pix_cnt_d;
            b_q         <= b_d;
            g_q         <= g_d;
            fb_wr_en    <= wr_en_d;
            fb_wr_addr  <= wr_addr_d;
            fb_wr_data  <= wr_data_d;
            frame_done  <= done_d;
            frame_error <= error_d;
            busy        <= busy_d;
`ifdef FRAME_RX_CHECKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    // Next-state, byte assembly and output decode.
    always_comb begin
        state_d   = state;
        phase_d   = phase;
        pix_cnt_d = pix_cnt;
        b_d       = b_q;
        g_d       = g_q;
        wr_en_d   = 1'b0;
        wr_addr_d = fb_wr_addr;
        wr_data_d = fb_wr_data;
        done_d    = 1'b0;
        error_d   = 1'b0;
`ifdef FRAME_RX_CHECKSUM_EN
        xor_d     = xor_q;
`endif

        case (state)
            SYNC0: begin
                if (rx_valid && rx_enable && (rx_byte == SYNC_BYTE0)) begin
                    state_d = SYNC1;
                end
            end

            SYNC1: begin
                if (rx_valid) begin
                    if (rx_byte == SYNC_BYTE1) begin
                        state_d   = PIXEL;
                        phase_d   = 2'd0;
                        pix_cnt_d = '0;
                        wr_addr_d = '0;
`ifdef FRAME_RX_CHECKSUM_EN
                        xor_d     = 8'd0;
`endif
                    end else if (rx_byte != SYNC_BYTE0) begin
                        state_d = SYNC0;
                    end
                end else if (expired_c) begin
                    error_d = 1'b1;
                    state_d = SYNC0;
                end
            end

            PIXEL: begin
                if (rx_valid) begin
`ifdef FRAME_RX_CHECKSUM_EN
                    xor_d = xor_q ^ rx_byte;
`endif
                    case (phase)
                        2'd0: begin
                            b_d     = rx_byte;
                            phase_d = 2'd1;
                        end
                        2'd1: begin
                            g_d     = rx_byte;
                            phase_d = 2'd2;
                        end
                        default: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = pix_cnt[ADDR_WIDTH-1:0];
                            wr_data_d = {rx_byte, g_q, b_q};
                            phase_d   = 2'd0;
                            pix_cnt_d = pix_cnt + CNT_W'(1);
                            if (pix_cnt == LAST_PIXEL) begin
`ifdef FRAME_RX_CHECKSUM_EN
                                state_d = CHECK;
`else
                                state_d = DONE;
`endif
                            end
                        end
                    endcase
                end else if (expired_c) begin
                    error_d = 1'b1;
                    state_d = SYNC0;
                end
            end

`ifdef FRAME_RX_CHECKSUM_EN
            CHECK: begin
                if (rx_valid) begin
                    if (rx_byte == xor_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = SYNC0;
                    end
                end else if (expired_c) begin
                    error_d = 1'b1;
                    state_d = SYNC0;
                end
            end
`endif

            DONE: begin
`ifndef FRAME_RX_CHECKSUM_EN
                done_d  = 1'b1;
`endif
                state_d = SYNC0;
            end

            default: begin
                state_d = SYNC0;
            end
        endcase

        busy_d = (state_d != SYNC0);
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed self-checking bench for uart_frame_rx (4x2 frame, timeout 100).
module tb_uart_frame_rx;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned T  = 100;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic          rx_enable;
    logic          fb_wr_en;
    logic [AW-1:0] fb_wr_addr;
    logic [23:0]   fb_wr_data;
    logic          frame_done;
    logic          frame_error;
    logic          busy;

    int tests_run = 0;
    int failures  = 0;

    int          wr_total   = 0;
    int          done_total = 0;
    int          err_total  = 0;
    int          both_total = 0;
    int          busy_total = 0;
    logic [2:0]  wr_addr_log [256];
    logic [23:0] wr_data_log [256];

    uart_frame_rx #(
        .IMG_WIDTH     (W),
        .IMG_HEIGHT    (H),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .rx_enable  (rx_enable),
        .fb_wr_en   (fb_wr_en),
        .fb_wr_addr (fb_wr_addr),
        .fb_wr_data (fb_wr_data),
        .frame_done (frame_done),
        .frame_error(frame_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Output monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (fb_wr_en) begin
            wr_addr_log[wr_total & 255] = fb_wr_addr;
            wr_data_log[wr_total & 255] = fb_wr_data;
            wr_total = wr_total + 1;
        end
        if (frame_done)                done_total = done_total + 1;
        if (frame_error)               err_total  = err_total + 1;
        if (frame_done && frame_error) both_total = both_total + 1;
        if (busy)                      busy_total = busy_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; consecutive calls are back-to-back.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix_byte(input logic [7:0] base, input int k);
        return 8'(base + 8'(k / 3) + 8'(16 * (k % 3)));
    endfunction

    function automatic logic [23:0] pix_word(input logic [7:0] base, input int i);
        logic [7:0] b;
        b = 8'(base + 8'(i));
        return {8'(b + 8'd32), 8'(b + 8'd16), b};
    endfunction

    function automatic logic [7:0] frame_xor(input logic [7:0] base);
        logic [7:0] x;
        x = 8'd0;
        for (int k = 0; k < 3 * W * H; k++) x = x ^ pix_byte(base, k);
        return x;
    endfunction

    task automatic send_payload(input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) send_byte(pix_byte(base, k));
    endtask

    task automatic send_frame(input logic [7:0] base, input logic [7:0] ck_flip);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_payload(base, 3 * W * H);
`ifdef FRAME_RX_CHECKSUM_EN
        send_byte(frame_xor(base) ^ ck_flip);
`else
        if (ck_flip != 8'd0) idle(1);
`endif
        idle(5);
    endtask

    task automatic check_writes(input string tag, input int w0, input int n, input logic [7:0] base);
        check({tag, "_wr_count"}, 32'(wr_total - w0), 32'(n));
        for (int i = 0; i < n; i++) begin
            check({tag, "_addr"}, 32'(wr_addr_log[(w0 + i) & 255]), 32'(i));
            check({tag, "_data"}, 32'(wr_data_log[(w0 + i) & 255]), 32'(pix_word(base, i)));
        end
    endtask

    initial begin
        int w0, d0, e0, b0;

        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;
        rx_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_wr_en",  32'(fb_wr_en),    32'd0);
        check("rst_addr",   32'(fb_wr_addr),  32'd0);
        check("rst_data",   32'(fb_wr_data),  32'd0);
        check("rst_done",   32'(frame_done),  32'd0);
        check("rst_error",  32'(frame_error), 32'd0);
        check("rst_busy",   32'(busy),        32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // Nominal frame with write latency and done timing checks.
        w0 = wr_total; d0 = done_total; e0 = err_total;
        send_byte(8'hAA);
        send_byte(8'h55);
        send_payload(8'd0, 3 * W * H);
        @(negedge clk);
        check("nom_last_wr_en",   32'(fb_wr_en),   32'd1);
        check("nom_last_wr_addr", 32'(fb_wr_addr), 32'd7);
`ifdef FRAME_RX_CHECKSUM_EN
        @(posedge clk);
        #1;
        send_byte(frame_xor(8'd0));
`endif
        @(negedge clk);
        check("nom_done_timing", 32'(frame_done), 32'd1);
        check("nom_busy_after",  32'(busy),       32'd0);
        @(posedge clk);
        #1;
        idle(4);
        check_writes("nom", w0, 8, 8'd0);
        check("nom_done_count", 32'(done_total - d0), 32'd1);
        check("nom_err_count",  32'(err_total - e0),  32'd0);

        // Header resync on stray and repeated sync bytes.
        w0 = wr_total; d0 = done_total; e0 = err_total;
        send_byte(8'h12);
        send_byte(8'hAA);
        send_byte(8'h12);
        send_byte(8'hAA);
        send_byte(8'hAA);
        send_byte(8'h55);
        send_payload(8'd3, 3 * W * H);
`ifdef FRAME_RX_CHECKSUM_EN
        send_byte(frame_xor(8'd3));
`endif
        idle(5);
        check_writes("resync", w0, 8, 8'd3);
        check("resync_done_count", 32'(done_total - d0), 32'd1);
        check("resync_err_count",  32'(err_total - e0),  32'd0);

        // rx_enable low: header ignored, nothing happens.
        w0 = wr_total; d0 = done_total; e0 = err_total; b0 = busy_total;
        rx_enable = 1'b0;
        send_byte(8'hAA);
        send_byte(8'h55);
        send_payload(8'd0, 24);
        idle(5);
        rx_enable = 1'b1;
        check("dis_wr_count",   32'(wr_total - w0),   32'd0);
        check("dis_busy_count", 32'(busy_total - b0), 32'd0);
        check("dis_done_count", 32'(done_total - d0), 32'd0);
        check("dis_err_count",  32'(err_total - e0),  32'd0);

        // Timeout after a partial frame, then a clean frame.
        w0 = wr_total; d0 = done_total; e0 = err_total;
        send_byte(8'hAA);
        send_byte(8'h55);
        send_payload(8'd0, 10);
        idle(T + 10);
        check_writes("tmo", w0, 3, 8'd0);
        check("tmo_err_count",  32'(err_total - e0),  32'd1);
        check("tmo_done_count", 32'(done_total - d0), 32'd0);
        check("tmo_busy",       32'(busy),            32'd0);
        w0 = wr_total; d0 = done_total; e0 = err_total;
        send_frame(8'd5, 8'd0);
        check_writes("post_tmo", w0, 8, 8'd5);
        check("post_tmo_done", 32'(done_total - d0), 32'd1);
        check("post_tmo_err",  32'(err_total - e0),  32'd0);

        // Reset in mid-frame after pixel 5.
        d0 = done_total; e0 = err_total;
        send_byte(8'hAA);
        send_byte(8'h55);
        send_payload(8'd0, 18);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_wr_en", 32'(fb_wr_en),    32'd0);
        check("mid_rst_addr",  32'(fb_wr_addr),  32'd0);
        check("mid_rst_data",  32'(fb_wr_data),  32'd0);
        check("mid_rst_busy",  32'(busy),        32'd0);
        check("mid_rst_done",  32'(frame_done),  32'd0);
        check("mid_rst_error", 32'(frame_error), 32'd0);
        idle(3);
        check("mid_rst_pulses", 32'((done_total - d0) + (err_total - e0)), 32'd0);
        w0 = wr_total; d0 = done_total;
        send_frame(8'd9, 8'd0);
        check_writes("post_rst", w0, 8, 8'd9);
        check("post_rst_done", 32'(done_total - d0), 32'd1);

`ifdef FRAME_RX_CHECKSUM_EN
        // Checksum good and bad.
        d0 = done_total; e0 = err_total;
        send_frame(8'd0, 8'd0);
        check("ck_good_done", 32'(done_total - d0), 32'd1);
        check("ck_good_err",  32'(err_total - e0),  32'd0);
        d0 = done_total; e0 = err_total;
        send_frame(8'd0, 8'h01);
        check("ck_bad_done", 32'(done_total - d0), 32'd0);
        check("ck_bad_err",  32'(err_total - e0),  32'd1);
`endif

        check("done_error_exclusive", 32'(both_total), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
